// File: rtl/nf10_10g_tx_port_filter.sv
// nf10_10g_tx_port_filter: drops packets not addressed to this port and narrows 256-bit beats to 64-bit MAC words
module nf10_10g_tx_port_filter #(
  parameter int C_S_AXIS_DATA_WIDTH = 256,
  parameter int C_M_AXIS_DATA_WIDTH = 64,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [7:0] C_PORT_MASK = 8'h40,
  parameter int C_DST_PORT_POS = 24
) (
  input  logic                                 axi_aclk,
  input  logic                                 axi_reset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
  input  logic                                 s_axis_tvalid,
  output logic                                 s_axis_tready,
  input  logic                                 s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  output logic [31:0]                          pkt_fwd_count,
  output logic [31:0]                          pkt_drop_count
);
  localparam logic [1:0] START = 2'd0, FWD = 2'd1, DROP = 2'd2;
  localparam int MW = C_M_AXIS_DATA_WIDTH;
  localparam int MS = C_M_AXIS_DATA_WIDTH / 8;
  logic [1:0] state, lane, last_lane, beat_last_lane;
  logic buf_valid, buf_last, match, accept, load, out_hs, last_out, unused_tuser;
  logic [C_S_AXIS_DATA_WIDTH-1:0] buf_data;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0] buf_strb;
  logic [31:0] fwd_cnt, drop_cnt;
  assign unused_tuser = ^s_axis_tuser;
  assign match = |(s_axis_tuser[C_DST_PORT_POS +: 8] & C_PORT_MASK);
  assign last_out = lane == last_lane;
  assign s_axis_tready = !axi_reset & (state == DROP | !buf_valid | (last_out & m_axis_tready));
  assign accept = s_axis_tvalid & s_axis_tready;
  assign load = accept & (state == FWD | (state == START & match));
  assign out_hs = buf_valid & m_axis_tready;
  assign m_axis_tvalid = !axi_reset & buf_valid;
  assign m_axis_tdata = axi_reset ? '0 : buf_data[int'(lane)*MW +: MW];
  assign m_axis_tstrb = axi_reset ? '0 : buf_strb[int'(lane)*MS +: MS];
  assign m_axis_tlast = !axi_reset & buf_valid & buf_last & last_out;
  assign pkt_fwd_count = fwd_cnt;
  assign pkt_drop_count = drop_cnt;
  // highest lane carrying any byte ends a last beat; an all-empty last beat still emits lane 0
  always_comb
    beat_last_lane = !s_axis_tlast ? 2'd3 :
                     |s_axis_tstrb[3*MS +: MS] ? 2'd3 :
                     |s_axis_tstrb[2*MS +: MS] ? 2'd2 :
                     |s_axis_tstrb[MS +: MS] ? 2'd1 : 2'd0;
  // packet state: the first beat's destination decides forward or drop for the whole packet
  always_ff @(posedge axi_aclk)
    if (axi_reset) state <= START;
    else if (accept) state <= s_axis_tlast ? START : state == START ? (match ? FWD : DROP) : state;
  // single-beat buffer; a reload on the final lane handshake keeps the output stream gapless
  always_ff @(posedge axi_aclk)
    if (axi_reset) begin
      buf_valid <= 1'b0;
      buf_last <= 1'b0;
      lane <= 2'd0;
      last_lane <= 2'd0;
      buf_data <= '0;
      buf_strb <= '0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_last <= s_axis_tlast;
      lane <= 2'd0;
      last_lane <= beat_last_lane;
      buf_data <= s_axis_tdata;
      buf_strb <= s_axis_tstrb;
    end else if (out_hs) begin
      buf_valid <= !last_out;
      lane <= last_out ? 2'd0 : lane + 2'd1;
    end
  // packet counters bump on acceptance of each first beat
  always_ff @(posedge axi_aclk)
    if (axi_reset) begin
      fwd_cnt <= '0;
      drop_cnt <= '0;
    end else if (accept && state == START) begin
      fwd_cnt <= fwd_cnt + {31'd0, match};
      drop_cnt <= drop_cnt + {31'd0, !match};
    end
endmodule

// File: tb/tb_nf10_10g_tx_port_filter.sv
// tb_nf10_10g_tx_port_filter: random and directed packets checked against a lane-queue model
module tb_nf10_10g_tx_port_filter;
  logic axi_aclk = 0, axi_reset = 1;
  logic [255:0] s_axis_tdata = '0;
  logic [31:0] s_axis_tstrb = '0;
  logic [127:0] s_axis_tuser = '0;
  logic s_axis_tvalid = 0, s_axis_tready, s_axis_tlast = 0;
  logic [63:0] m_axis_tdata;
  logic [7:0] m_axis_tstrb;
  logic m_axis_tvalid, m_axis_tready = 1, m_axis_tlast;
  logic [31:0] pkt_fwd_count, pkt_drop_count;
  nf10_10g_tx_port_filter dut (
    .axi_aclk(axi_aclk), .axi_reset(axi_reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .pkt_fwd_count(pkt_fwd_count), .pkt_drop_count(pkt_drop_count));
  always #5 axi_aclk = ~axi_aclk;
  int tests = 0, fails = 0;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  typedef struct {logic [63:0] d; logic [7:0] s; logic l;} beat_t;
  beat_t mq[$];
  logic [31:0] m_fwd = 0, m_drop = 0;
  bit m_first = 1, m_keep = 0;
  int n_out = 0, cyc = 0, hs_cyc[$];
  logic [7:0] last_strb;
  logic last_tlast;
  int mode = 0;
  always @(posedge axi_aclk) begin
    #1;
    m_axis_tready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom % 2) : !m_axis_tready;
  end
  // model: an accepted first beat decides keep/drop; kept beats expand into their lanes
  function automatic void model_accept();
    int nl;
    if (m_first) begin
      m_keep = |(s_axis_tuser[31:24] & 8'h40);
      if (m_keep) m_fwd++;
      else m_drop++;
    end
    if (m_keep) begin
      nl = 3;
      if (s_axis_tlast) begin
        nl = 0;
        for (int k = 0; k < 4; k++) if (s_axis_tstrb[8*k +: 8] != 0) nl = k;
      end
      for (int k = 0; k <= nl; k++) mq.push_back('{s_axis_tdata[64*k +: 64], s_axis_tstrb[8*k +: 8], s_axis_tlast && k == nl});
    end
    m_first = s_axis_tlast;
  endfunction
  logic p_stall = 0, p_rst = 1, p_l;
  logic [63:0] p_d;
  logic [7:0] p_s;
  beat_t e;
  always @(negedge axi_aclk) begin
    cyc++;
    if (axi_reset) begin
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_s_tready", s_axis_tready, 0);
      chk("rst_m_tdata", m_axis_tdata, 0);
      chk("rst_m_tstrb", m_axis_tstrb, 0);
      chk("rst_m_tlast", m_axis_tlast, 0);
      if (p_rst) begin
        chk("rst_fwd_count", pkt_fwd_count, 0);
        chk("rst_drop_count", pkt_drop_count, 0);
      end
      mq.delete();
      m_fwd = 0;
      m_drop = 0;
      m_first = 1;
    end else begin
      chk("fwd_count", pkt_fwd_count, m_fwd);
      chk("drop_count", pkt_drop_count, m_drop);
      if (p_stall) begin
        chk("stall_tvalid", m_axis_tvalid, 1);
        chk("stall_tdata", m_axis_tdata, p_d);
        chk("stall_tstrb", m_axis_tstrb, p_s);
        chk("stall_tlast", m_axis_tlast, p_l);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (mq.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = mq.pop_front();
          chk("out_tdata", m_axis_tdata, e.d);
          chk("out_tstrb", m_axis_tstrb, e.s);
          chk("out_tlast", m_axis_tlast, e.l);
        end
        n_out++;
        hs_cyc.push_back(cyc);
        last_strb = m_axis_tstrb;
        last_tlast = m_axis_tlast;
      end
      if (s_axis_tvalid && s_axis_tready) model_accept();
    end
    p_stall = !axi_reset && m_axis_tvalid && !m_axis_tready;
    p_d = m_axis_tdata;
    p_s = m_axis_tstrb;
    p_l = m_axis_tlast;
    p_rst = axi_reset;
  end
  task automatic step();
    @(posedge axi_aclk);
    #1;
  endtask
  task automatic send_beat(input logic [7:0] dst, input logic last, input logic [31:0] strb, output int waits);
    s_axis_tdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    s_axis_tuser = {$urandom, $urandom, $urandom, $urandom};
    s_axis_tuser[31:24] = dst;
    s_axis_tstrb = strb;
    s_axis_tlast = last;
    s_axis_tvalid = 1;
    waits = 0;
    @(negedge axi_aclk);
    while (!s_axis_tready && waits < 2000) begin
      waits++;
      @(negedge axi_aclk);
    end
    if (waits >= 2000) chk("accept_timeout", 1, 0);
    step();
    s_axis_tvalid = 0;
  endtask
  task automatic send_pkt(input logic [7:0] dst, input int n, input logic [31:0] last_strb, input bit gap);
    int w;
    for (int i = 0; i < n; i++) begin
      send_beat(i == 0 ? dst : 8'($urandom), i == n - 1, i == n - 1 ? last_strb : $urandom, w);
      if (gap) repeat ($urandom_range(0, 2)) step();
    end
  endtask
  task automatic wait_idle();
    int k = 0;
    @(negedge axi_aclk);
    while ((mq.size() != 0 || m_axis_tvalid) && k < 5000) begin
      k++;
      @(negedge axi_aclk);
    end
    if (k >= 5000) chk("drain_timeout", 1, 0);
    step();
  endtask
  initial begin
    int n0, h0, w1, w2, w3, n;
    logic [7:0] dst;
    logic [31:0] strb;
    repeat (3) step();
    axi_reset = 0;
    @(negedge axi_aclk);
    chk("tready_after_reset", s_axis_tready, 1);
    step();
    n0 = n_out;
    send_pkt(8'h40, 1, 32'h0000FFFF, 0);
    wait_idle();
    chk("single_nout", n_out - n0, 2);
    chk("single_strb", last_strb, 8'hFF);
    chk("single_tlast", last_tlast, 1);
    chk("single_fwd", pkt_fwd_count, 1);
    n0 = n_out;
    send_beat(8'h01, 0, '1, w1);
    send_beat(8'h40, 0, '1, w2);
    send_beat(8'h40, 1, '1, w3);
    step();
    chk("drop_waits", w1 + w2 + w3, 0);
    chk("drop_nout", n_out - n0, 0);
    chk("drop_count_lit", pkt_drop_count, 1);
    send_pkt(8'h40, 1, '1, 0);
    wait_idle();
    chk("after_drop_nout", n_out - n0, 4);
    chk("after_drop_fwd", pkt_fwd_count, 2);
    n0 = n_out;
    h0 = hs_cyc.size();
    send_beat(8'h55, 0, $urandom, w1);
    send_beat(8'h00, 1, 32'h0000_0007, w2);
    chk("b2b_wait", w2, 3);
    wait_idle();
    chk("b2b_nout", n_out - n0, 5);
    chk("b2b_span", hs_cyc[hs_cyc.size()-1] - hs_cyc[h0], 4);
    chk("b2b_strb", last_strb, 8'h07);
    chk("b2b_tlast", last_tlast, 1);
    n0 = n_out;
    send_pkt(8'hC0, 1, 32'h0, 0);
    wait_idle();
    chk("empty_nout", n_out - n0, 1);
    chk("empty_strb", last_strb, 8'h00);
    chk("empty_tlast", last_tlast, 1);
    mode = 2;
    n0 = n_out;
    send_pkt(8'h40, 3, 32'h00FF_FFFF, 0);
    wait_idle();
    chk("toggle_nout", n_out - n0, 11);
    for (int p = 0; p < 80; p++) begin
      mode = $urandom_range(0, 2);
      dst = 8'($urandom);
      dst = ($urandom % 2) ? (dst | 8'h40) : (dst & 8'hBF);
      n = $urandom_range(1, 5);
      strb = $urandom;
      for (int k = 0; k < 4; k++) if ($urandom % 3 == 0) strb[8*k +: 8] = 8'h00;
      send_pkt(dst, n, strb, 1'($urandom % 2));
    end
    mode = 0;
    wait_idle();
    force dut.fwd_cnt = 32'hFFFF_FFFF;
    m_fwd = 32'hFFFF_FFFF;
    step();
    release dut.fwd_cnt;
    step();
    chk("preload_fwd", pkt_fwd_count, 32'hFFFF_FFFF);
    send_pkt(8'h40, 2, '1, 0);
    wait_idle();
    chk("wrap_fwd", pkt_fwd_count, 0);
    send_beat(8'h40, 0, '1, w1);
    send_beat(8'h00, 0, '1, w2);
    axi_reset = 1;
    @(negedge axi_aclk);
    chk("midrst_tvalid", m_axis_tvalid, 0);
    chk("midrst_tready", s_axis_tready, 0);
    step();
    @(negedge axi_aclk);
    chk("midrst_fwd", pkt_fwd_count, 0);
    chk("midrst_tdata", m_axis_tdata, 0);
    step();
    axi_reset = 0;
    n0 = n_out;
    send_pkt(8'h40, 1, 32'h000F_FFFF, 0);
    wait_idle();
    chk("postrst_nout", n_out - n0, 3);
    chk("postrst_fwd", pkt_fwd_count, 1);
    chk("postrst_tlast", last_tlast, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
